execute_stage: RTL and testbench

Execute stage sitting directly downstream of the decode/execute pipeline register. It consumes that register's outputs and computes the ALU result, store data and destination register for the execute/memory register. Single-cycle ALU ops are combinational. MULT/MULTU/DIV/DIVU run on an iterative multiply/divide unit that owns the HI/LO registers. While that unit is busy, the stage raises `stall_o`, which drives `en_pipeline` low upstream.

---
 rtl/execute_stage_pkg.sv | 64 ++++++
 rtl/md_unit.sv | 128 ++++++++++++
 rtl/execute_stage.sv | 129 ++++++++++++
 tb/tb_execute_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/execute_stage_pkg.sv
// Shared constants for the execute stage: opcodes, R-type function codes,
// destination-select encodings and the multiply/divide FSM state type.
package execute_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_LWU   = 6'h27;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [1:0] RD_RT     = 2'b00;
    localparam logic [1:0] RD_RD     = 2'b01;
    localparam logic [1:0] RD_R31    = 2'b10;
    localparam logic [1:0] RD_RD_ALT = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    function automatic logic is_md_fn(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
    endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per
// negedge, owning the architectural HI/LO registers.
module md_unit
    import execute_stage_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_i,
    input  logic               is_signed_i,
    input  logic               is_div_i,
    input  logic [NB_DATA-1:0] op_a_i,
    input  logic [NB_DATA-1:0] op_b_i,
    output logic               busy_o,
    output logic [NB_DATA-1:0] hi_o,
    output logic [NB_DATA-1:0] lo_o
);

    localparam int NB_CNT = $clog2(NB_DATA);
    localparam logic [NB_CNT-1:0] LAST_STEP = NB_CNT'(NB_DATA - 1);

    md_state_t          r_state;
    logic [NB_CNT-1:0]  r_count;
    logic               r_div;
    logic               r_div_zero;
    logic               r_neg_a;
    logic               r_neg_b;
    logic [NB_DATA-1:0] r_operand;
    logic [NB_DATA-1:0] r_work_hi;
    logic [NB_DATA-1:0] r_work_lo;
    logic [NB_DATA-1:0] r_hi;
    logic [NB_DATA-1:0] r_lo;

    logic               w_neg_a;
    logic               w_neg_b;
    logic [NB_DATA-1:0] w_abs_a;
    logic [NB_DATA-1:0] w_abs_b;
    logic [NB_DATA:0]   w_add;
    logic [NB_DATA:0]   w_rem_sh;
    logic [NB_DATA:0]   w_trial;
    logic [NB_DATA-1:0] w_next_hi;
    logic [NB_DATA-1:0] w_next_lo;
    logic [2*NB_DATA-1:0] w_prod;
    logic [2*NB_DATA-1:0] w_prod_fix;
    logic [NB_DATA-1:0] w_quot_fix;
    logic [NB_DATA-1:0] w_rem_fix;

    assign w_neg_a = is_signed_i & op_a_i[NB_DATA-1];
    assign w_neg_b = is_signed_i & op_b_i[NB_DATA-1];
    assign w_abs_a = w_neg_a ? -op_a_i : op_a_i;
    assign w_abs_b = w_neg_b ? -op_b_i : op_b_i;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_add     = {1'b0, r_work_hi} + (r_work_lo[0] ? {1'b0, r_operand} : '0);
        w_rem_sh  = {r_work_hi, r_work_lo[NB_DATA-1]};
        w_trial   = w_rem_sh - {1'b0, r_operand};
        w_next_hi = w_add[NB_DATA:1];
        w_next_lo = {w_add[0], r_work_lo[NB_DATA-1:1]};
        if (r_div) begin
            // A clear borrow bit means the trial subtraction fits: keep it, quotient bit 1.
            w_next_hi = w_trial[NB_DATA] ? w_rem_sh[NB_DATA-1:0] : w_trial[NB_DATA-1:0];
            w_next_lo = {r_work_lo[NB_DATA-2:0], ~w_trial[NB_DATA]};
        end
    end

    assign w_prod     = {w_next_hi, w_next_lo};
    assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
    assign w_quot_fix = ((r_neg_a ^ r_neg_b) && !r_div_zero) ? -w_next_lo : w_next_lo;
    assign w_rem_fix  = r_neg_a ? -w_next_hi : w_next_hi;

    // Stall must vanish the moment reset is asserted, even with an MD op still presented.
    assign busy_o = reset && (((r_state == MD_IDLE) && start_i) || (r_state == MD_BUSY));
    assign hi_o   = r_hi;
    assign lo_o   = r_lo;

    // NOTE: non-blocking assignments keep every register updating from pre-edge values, as flip-flops do.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= MD_IDLE;
            r_count    <= '0;
            r_div      <= 1'b0;
            r_div_zero <= 1'b0;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_operand  <= '0;
            r_work_hi  <= '0;
            r_work_lo  <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (start_i) begin
                        r_state    <= MD_BUSY;
                        r_count    <= '0;
                        r_div      <= is_div_i;
                        r_div_zero <= (op_b_i == '0);
                        r_neg_a    <= w_neg_a;
                        r_neg_b    <= w_neg_b;
                        r_operand  <= is_div_i ? w_abs_b : w_abs_a;
                        r_work_hi  <= '0;
                        r_work_lo  <= is_div_i ? w_abs_a : w_abs_b;
                    end
                end
                MD_BUSY: begin
                    r_work_hi <= w_next_hi;
                    r_work_lo <= w_next_lo;
                    r_count   <= r_count + 1'b1;
                    if (r_count == LAST_STEP) begin
                        r_state <= MD_DONE;
                        if (r_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quot_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*NB_DATA-1:NB_DATA];
                            r_lo <= w_prod_fix[NB_DATA-1:0];
                        end
                    end
                end
                MD_DONE: r_state <= MD_IDLE;
                default: r_state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: combinational ALU, destination select and control pass-through,
// with an iterative MD unit that stalls the pipeline while it works.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int NB_DATA     = 32,
    parameter int NB_REG      = 5,
    parameter int NB_FUNCTION = 6,
    parameter int NB_OP       = 6,
    parameter int N_REGDEST   = 2,
    parameter int NB_PC       = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NB_PC-1:0]       pc_i,
    input  logic [NB_DATA-1:0]     data_ra_i,
    input  logic [NB_DATA-1:0]     data_rb_i,
    input  logic [NB_DATA-1:0]     inm_ext_i,
    input  logic                   tipeI_i,
    input  logic [NB_FUNCTION-1:0] function_i,
    input  logic [NB_OP-1:0]       opcode_i,
    input  logic [NB_REG-1:0]      register_b_i,
    input  logic [NB_REG-1:0]      register_rw_i,
    input  logic [N_REGDEST-1:0]   regDest_signal_i,
    input  logic [5:0]             mem_signals_i,
    input  logic [2:0]             wb_signals_i,
    input  logic                   halt_signal_i,
    output logic [NB_DATA-1:0]     alu_result_o,
    output logic [NB_DATA-1:0]     data_store_o,
    output logic [NB_REG-1:0]      register_dest_o,
    output logic [5:0]             mem_signals_o,
    output logic [2:0]             wb_signals_o,
    output logic                   halt_signal_o,
    output logic                   stall_o
);

    logic [NB_DATA-1:0] w_op_b;
    logic [NB_DATA-1:0] w_imm_zext;
    logic [NB_DATA-1:0] w_pc_zext;
    logic [4:0]         w_shamt;
    logic [4:0]         w_shamt_v;
    logic               w_is_rtype;
    logic               w_md_start;
    logic               w_md_busy;
    logic [NB_DATA-1:0] w_hi;
    logic [NB_DATA-1:0] w_lo;
    logic [NB_DATA-1:0] w_alu;

    assign w_op_b     = tipeI_i ? inm_ext_i : data_rb_i;
    assign w_imm_zext = {{(NB_DATA-16){1'b0}}, inm_ext_i[15:0]};
    assign w_pc_zext  = {{(NB_DATA-NB_PC){1'b0}}, pc_i};
    assign w_shamt    = inm_ext_i[10:6];
    assign w_shamt_v  = data_ra_i[4:0];
    assign w_is_rtype = (opcode_i == OP_RTYPE);

    // A halted instruction never starts the MD unit, so HI/LO keep their values.
    assign w_md_start = w_is_rtype && is_md_fn(function_i) && !halt_signal_i;

    md_unit #(.NB_DATA(NB_DATA)) u_md_unit (
        .clock       (clock),
        .reset       (reset),
        .start_i     (w_md_start),
        .is_signed_i ((function_i == FN_MULT) || (function_i == FN_DIV)),
        .is_div_i    ((function_i == FN_DIV) || (function_i == FN_DIVU)),
        .op_a_i      (data_ra_i),
        .op_b_i      (data_rb_i),
        .busy_o      (w_md_busy),
        .hi_o        (w_hi),
        .lo_o        (w_lo)
    );

    always_comb begin
        w_alu = '0;
        if (w_is_rtype) begin
            case (function_i)
                FN_SLL:           w_alu = w_op_b << w_shamt;
                FN_SRL:           w_alu = w_op_b >> w_shamt;
                FN_SRA:           w_alu = $signed(w_op_b) >>> w_shamt;
                FN_SLLV:          w_alu = w_op_b << w_shamt_v;
                FN_SRLV:          w_alu = w_op_b >> w_shamt_v;
                FN_SRAV:          w_alu = $signed(w_op_b) >>> w_shamt_v;
                FN_JALR:          w_alu = w_pc_zext;
                FN_MFHI:          w_alu = w_hi;
                FN_MFLO:          w_alu = w_lo;
                FN_ADD, FN_ADDU:  w_alu = data_ra_i + w_op_b;
                FN_SUB, FN_SUBU:  w_alu = data_ra_i - w_op_b;
                FN_AND:           w_alu = data_ra_i & w_op_b;
                FN_OR:            w_alu = data_ra_i | w_op_b;
                FN_XOR:           w_alu = data_ra_i ^ w_op_b;
                FN_NOR:           w_alu = ~(data_ra_i | w_op_b);
                FN_SLT:           w_alu = {{(NB_DATA-1){1'b0}}, $signed(data_ra_i) < $signed(w_op_b)};
                FN_SLTU:          w_alu = {{(NB_DATA-1){1'b0}}, data_ra_i < w_op_b};
                default:          w_alu = '0;
            endcase
        end else begin
            case (opcode_i)
                OP_ADDI, OP_ADDIU: w_alu = data_ra_i + w_op_b;
                OP_SLTI:           w_alu = {{(NB_DATA-1){1'b0}}, $signed(data_ra_i) < $signed(w_op_b)};
                OP_SLTIU:          w_alu = {{(NB_DATA-1){1'b0}}, data_ra_i < w_op_b};
                OP_ANDI:           w_alu = data_ra_i & w_imm_zext;
                OP_ORI:            w_alu = data_ra_i | w_imm_zext;
                OP_XORI:           w_alu = data_ra_i ^ w_imm_zext;
                OP_LUI:            w_alu = {inm_ext_i[15:0], {(NB_DATA-16){1'b0}}};
                OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU,
                OP_SB, OP_SH, OP_SW: w_alu = data_ra_i + inm_ext_i;
                OP_JAL:            w_alu = w_pc_zext;
                default:           w_alu = '0;
            endcase
        end
    end

    always_comb begin
        register_dest_o = register_rw_i;
        case (regDest_signal_i)
            RD_RT:            register_dest_o = register_b_i;
            RD_R31:           register_dest_o = NB_REG'(31);
            RD_RD, RD_RD_ALT: register_dest_o = register_rw_i;
            default:          register_dest_o = register_rw_i;
        endcase
    end

    assign alu_result_o  = w_alu;
    assign data_store_o  = data_rb_i;
    assign stall_o       = w_md_busy;
    assign mem_signals_o = w_md_busy ? 6'b0 : mem_signals_i;
    assign wb_signals_o  = w_md_busy ? 3'b0 : wb_signals_i;
    assign halt_signal_o = halt_signal_i;

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage: ALU ops, destination select,
// multiply/divide results and stall length, reset abort and halt suppression.
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic        clock;
    logic        reset;
    logic [6:0]  pc_i;
    logic [31:0] data_ra_i;
    logic [31:0] data_rb_i;
    logic [31:0] inm_ext_i;
    logic        tipeI_i;
    logic [5:0]  function_i;
    logic [5:0]  opcode_i;
    logic [4:0]  register_b_i;
    logic [4:0]  register_rw_i;
    logic [1:0]  regDest_signal_i;
    logic [5:0]  mem_signals_i;
    logic [2:0]  wb_signals_i;
    logic        halt_signal_i;
    logic [31:0] alu_result_o;
    logic [31:0] data_store_o;
    logic [4:0]  register_dest_o;
    logic [5:0]  mem_signals_o;
    logic [2:0]  wb_signals_o;
    logic        halt_signal_o;
    logic        stall_o;

    int n_checks = 0;
    int n_errors = 0;

    execute_stage dut (
        .clock            (clock),
        .reset            (reset),
        .pc_i             (pc_i),
        .data_ra_i        (data_ra_i),
        .data_rb_i        (data_rb_i),
        .inm_ext_i        (inm_ext_i),
        .tipeI_i          (tipeI_i),
        .function_i       (function_i),
        .opcode_i         (opcode_i),
        .register_b_i     (register_b_i),
        .register_rw_i    (register_rw_i),
        .regDest_signal_i (regDest_signal_i),
        .mem_signals_i    (mem_signals_i),
        .wb_signals_i     (wb_signals_i),
        .halt_signal_i    (halt_signal_i),
        .alu_result_o     (alu_result_o),
        .data_store_o     (data_store_o),
        .register_dest_o  (register_dest_o),
        .mem_signals_o    (mem_signals_o),
        .wb_signals_o     (wb_signals_o),
        .halt_signal_o    (halt_signal_o),
        .stall_o          (stall_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] ra,
                         input logic [31:0] rb, input logic [31:0] imm, input logic tipe);
        opcode_i         = op;
        function_i       = fn;
        data_ra_i        = ra;
        data_rb_i        = rb;
        inm_ext_i        = imm;
        tipeI_i          = tipe;
        halt_signal_i    = 1'b0;
        regDest_signal_i = RD_RD;
    endtask

    // Inputs change on posedge; state moves on negedge, so posedge+1 is a quiet sample point.
    task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] ra,
                         input logic [31:0] rb, input logic [31:0] imm, input logic tipe);
        @(posedge clock);
        drive(op, fn, ra, rb, imm, tipe);
        #1;
    endtask

    task automatic run_md(input string tag, input logic [5:0] fn, input logic [31:0] ra,
                          input logic [31:0] rb);
        int cycles;
        int leaks;
        cycles = 0;
        leaks  = 0;
        apply(OP_RTYPE, fn, ra, rb, 32'h0, 1'b0);
        while (stall_o && cycles < 100) begin
            cycles++;
            if (mem_signals_o != 6'h0 || wb_signals_o != 3'h0) leaks++;
            @(posedge clock);
            #1;
        end
        check({tag, "_stall_cycles"}, 32'(cycles), 32'd33);
        check({tag, "_bubble_leaks"}, 32'(leaks), 32'd0);
        check({tag, "_done_mem"}, {26'b0, mem_signals_o}, 32'h2A);
    endtask

    initial begin
        reset         = 1'b0;
        pc_i          = 7'h55;
        register_b_i  = 5'd9;
        register_rw_i = 5'd17;
        mem_signals_i = 6'h2A;
        wb_signals_i  = 3'h5;
        drive(OP_RTYPE, FN_ADDU, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0);
        #1;
        check("reset_stall", {31'b0, stall_o}, 32'h0);
        check("reset_comb_addu", alu_result_o, 32'h8000_0000);
        @(posedge clock);
        reset = 1'b1;

        apply(OP_RTYPE, FN_ADDU, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0);
        check("addu_wrap", alu_result_o, 32'h8000_0000);
        check("store_data", data_store_o, 32'h1);
        check("wb_pass", {29'b0, wb_signals_o}, 32'h5);
        apply(OP_RTYPE, FN_SLT, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
        check("slt_signed", alu_result_o, 32'h1);
        apply(OP_RTYPE, FN_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
        check("sltu_unsigned", alu_result_o, 32'h0);
        apply(OP_RTYPE, FN_SUB, 32'h5, 32'h7, 32'h0, 1'b0);
        check("sub_neg", alu_result_o, 32'hFFFF_FFFE);
        apply(OP_RTYPE, FN_SRA, 32'h0, 32'h8000_0000, 32'h0000_0100, 1'b0);
        check("sra_shamt4", alu_result_o, 32'hF800_0000);
        apply(OP_RTYPE, FN_SLLV, 32'h4, 32'h1, 32'h0, 1'b0);
        check("sllv", alu_result_o, 32'h10);
        apply(OP_RTYPE, FN_NOR, 32'hF0F0_0000, 32'h0000_00FF, 32'h0, 1'b0);
        check("nor", alu_result_o, 32'h0F0F_FF00);
        apply(OP_RTYPE, FN_JALR, 32'h0, 32'h0, 32'h0, 1'b0);
        check("jalr_pc", alu_result_o, 32'h55);
        apply(OP_ORI, 6'h0, 32'h1234_0000, 32'h0, 32'hFFFF_8000, 1'b1);
        check("ori_zext", alu_result_o, 32'h1234_8000);
        apply(OP_LUI, 6'h0, 32'h0, 32'h0, 32'h0000_1234, 1'b1);
        check("lui", alu_result_o, 32'h1234_0000);
        apply(OP_SLTI, 6'h0, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 1'b1);
        check("slti", alu_result_o, 32'h1);
        apply(OP_LW, 6'h0, 32'h100, 32'h0, 32'hFFFF_FFFC, 1'b1);
        check("lw_addr", alu_result_o, 32'hFC);
        apply(OP_JAL, 6'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        check("jal_pc", alu_result_o, 32'h55);
        apply(6'h3F, 6'h0, 32'h1, 32'h1, 32'h1, 1'b1);
        check("unlisted_op", alu_result_o, 32'h0);

        regDest_signal_i = RD_RT;
        #1 check("dest_rt", {27'b0, register_dest_o}, 32'd9);
        regDest_signal_i = RD_R31;
        #1 check("dest_r31", {27'b0, register_dest_o}, 32'd31);
        regDest_signal_i = RD_RD_ALT;
        #1 check("dest_rd_alt", {27'b0, register_dest_o}, 32'd17);

        run_md("mult", FN_MULT, 32'hFFFF_FFFD, 32'h5);
        apply(OP_RTYPE, FN_MFLO, 32'h0, 32'h0, 32'h0, 1'b0);
        check("mult_lo", alu_result_o, 32'hFFFF_FFF1);
        apply(OP_RTYPE, FN_MFHI, 32'h0, 32'h0, 32'h0, 1'b0);
        check("mult_hi", alu_result_o, 32'hFFFF_FFFF);

        run_md("multu", FN_MULTU, 32'hFFFF_FFFF, 32'h2);
        apply(OP_RTYPE, FN_MFHI, 32'h0, 32'h0, 32'h0, 1'b0);
        check("multu_hi", alu_result_o, 32'h1);
        apply(OP_RTYPE, FN_MFLO, 32'h0, 32'h0, 32'h0, 1'b0);
        check("multu_lo", alu_result_o, 32'hFFFF_FFFE);

        run_md("div", FN_DIV, 32'hFFFF_FFF9, 32'h2);
        apply(OP_RTYPE, FN_MFLO, 32'h0, 32'h0, 32'h0, 1'b0);
        check("div_lo", alu_result_o, 32'hFFFF_FFFD);
        apply(OP_RTYPE, FN_MFHI, 32'h0, 32'h0, 32'h0, 1'b0);
        check("div_hi", alu_result_o, 32'hFFFF_FFFF);

        run_md("divu0", FN_DIVU, 32'h7, 32'h0);
        apply(OP_RTYPE, FN_MFLO, 32'h0, 32'h0, 32'h0, 1'b0);
        check("divu0_lo", alu_result_o, 32'hFFFF_FFFF);
        apply(OP_RTYPE, FN_MFHI, 32'h0, 32'h0, 32'h0, 1'b0);
        check("divu0_hi", alu_result_o, 32'h7);

        // Abort a multiply at iteration 10: one negedge to latch, ten more to step.
        @(posedge clock);
        drive(OP_RTYPE, FN_MULT, 32'h1234_5678, 32'h3, 32'h0, 1'b0);
        repeat (11) @(negedge clock);
        #2 reset = 1'b0;
        #1 check("abort_stall", {31'b0, stall_o}, 32'h0);
        check("abort_mem", {26'b0, mem_signals_o}, 32'h2A);
        drive(OP_RTYPE, FN_MFHI, 32'h0, 32'h0, 32'h0, 1'b0);
        @(posedge clock);
        reset = 1'b1;
        #1 check("abort_hi", alu_result_o, 32'h0);
        apply(OP_RTYPE, FN_MFLO, 32'h0, 32'h0, 32'h0, 1'b0);
        check("abort_lo", alu_result_o, 32'h0);

        run_md("mult34", FN_MULT, 32'h3, 32'h4);
        apply(OP_RTYPE, FN_MFLO, 32'h0, 32'h0, 32'h0, 1'b0);
        check("mult34_lo", alu_result_o, 32'hC);
        apply(OP_RTYPE, FN_MFHI, 32'h0, 32'h0, 32'h0, 1'b0);
        check("mult34_hi", alu_result_o, 32'h0);

        @(posedge clock);
        drive(OP_RTYPE, FN_MULT, 32'h2, 32'h2, 32'h0, 1'b0);
        halt_signal_i = 1'b1;
        #1 check("halt_no_stall", {31'b0, stall_o}, 32'h0);
        check("halt_pass", {31'b0, halt_signal_o}, 32'h1);
        @(posedge clock);
        #1 check("halt_no_stall_2", {31'b0, stall_o}, 32'h0);
        apply(OP_RTYPE, FN_MFLO, 32'h0, 32'h0, 32'h0, 1'b0);
        check("halt_lo_kept", alu_result_o, 32'hC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
